// File: rtl/spi_adc_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_adc_if
// Brief    : ADC serial link pins (CS, SCK, SDI, SDO, SDO output-enable).
// Revision : 1.0 - initial release
// ============================================================================
interface spi_adc_if;
  logic adc_cs;
  logic adc_sck;
  logic sdata_to_adc;
  logic sdata_from_adc;
  logic sdo_oe;

  modport master (
    output adc_cs,
    output adc_sck,
    output sdata_to_adc,
    input  sdata_from_adc,
    input  sdo_oe
  );

  modport slave (
    input  adc_cs,
    input  adc_sck,
    input  sdata_to_adc,
    output sdata_from_adc,
    output sdo_oe
  );
endinterface
`default_nettype wire

// File: rtl/spi_adc_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_adc_responder
// Brief    : MCP3002-style two-channel 10-bit ADC emulator on the SPI pins.
// Revision : 1.0 - initial release
// ============================================================================
module spi_adc_responder (
  input  wire        sysclk,
  input  wire        reset,
  spi_adc_if.slave   adc,
  input  wire  [9:0] ch0_value,
  input  wire  [9:0] ch1_value,
  output logic       conv_done,
  output logic [1:0] last_cmd,
  output logic [7:0] conv_count
);

  localparam logic [2:0] c_IDLE       = 3'd0;
  localparam logic [2:0] c_WAIT_START = 3'd1;
  localparam logic [2:0] c_CMD        = 3'd2;
  localparam logic [2:0] c_NULLBIT    = 3'd3;
  localparam logic [2:0] c_DATA       = 3'd4;
  localparam logic [2:0] c_TRAIL      = 3'd5;
  localparam logic [3:0] c_MSB_IDX    = 4'd9;

  logic [2:0]  r_cs_sync, r_sck_sync, r_sdi_sync;
  logic        w_cs_high, w_cs_fall, w_sck_rise, w_sck_fall, w_sdi;
  logic [2:0]  r_state, w_next_state;
  logic [1:0]  r_bit_cnt;
  logic        r_sgl, r_odd, r_msbf;
  logic [9:0]  r_sample, w_sample;
  logic [10:0] w_diff;
  logic [3:0]  r_idx;
  logic        r_d0_sent, r_lsb_phase, r_sdo, r_conv_done;
  logic [1:0]  r_last_cmd;
  logic [7:0]  r_conv_count;
  logic        w_sdo_oe;

  // Stages [0],[1] synchronise, [2] is the history flop for edge detection.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_cs_sync  <= 3'b000;
      r_sck_sync <= 3'b000;
      r_sdi_sync <= 3'b000;
    end else begin
      r_cs_sync  <= {r_cs_sync[1:0], adc.adc_cs};
      r_sck_sync <= {r_sck_sync[1:0], adc.adc_sck};
      r_sdi_sync <= {r_sdi_sync[1:0], adc.sdata_to_adc};
    end
  end

  assign w_cs_high  = r_cs_sync[1];
  assign w_cs_fall  = ~r_cs_sync[1] & r_cs_sync[2];
  assign w_sck_rise = r_sck_sync[1] & ~r_sck_sync[2];
  assign w_sck_fall = ~r_sck_sync[1] & r_sck_sync[2];
  // SDI taken one stage later than SCK: still well inside the hold window.
  assign w_sdi      = r_sdi_sync[2];

  always_comb begin
    w_diff   = 11'd0;
    w_sample = 10'd0;
    if (r_sgl) begin
      w_sample = r_odd ? ch1_value : ch0_value;
    end else begin
      w_diff   = r_odd ? ({1'b0, ch1_value} - {1'b0, ch0_value})
                       : ({1'b0, ch0_value} - {1'b0, ch1_value});
      w_sample = w_diff[10] ? 10'd0 : w_diff[9:0];
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) r_state <= c_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (w_cs_high) begin
      w_next_state = c_IDLE;
    end else begin
      case (r_state)
        c_IDLE:       if (w_cs_fall) w_next_state = c_WAIT_START;
        c_WAIT_START: if (w_sck_rise && w_sdi) w_next_state = c_CMD;
        c_CMD:        if (w_sck_rise && r_bit_cnt == 2'd2) w_next_state = c_NULLBIT;
        c_NULLBIT:    if (w_sck_fall) w_next_state = c_DATA;
        c_DATA: begin
          if (r_lsb_phase) begin
            if (w_sck_fall && r_idx == c_MSB_IDX) w_next_state = c_TRAIL;
          end else if (r_d0_sent && w_sck_rise && r_msbf) begin
            w_next_state = c_TRAIL;
          end
        end
        c_TRAIL:      w_next_state = c_TRAIL;
        default:      w_next_state = c_IDLE;
      endcase
    end
  end

  always_comb begin
    w_sdo_oe = 1'b0;
    if (r_state == c_DATA || r_state == c_TRAIL) w_sdo_oe = 1'b1;
  end

  assign adc.sdo_oe         = w_sdo_oe;
  assign adc.sdata_from_adc = w_sdo_oe & r_sdo;
  assign conv_done          = r_conv_done;
  assign last_cmd           = r_last_cmd;
  assign conv_count         = r_conv_count;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_bit_cnt    <= 2'd0;
      r_sgl        <= 1'b0;
      r_odd        <= 1'b0;
      r_msbf       <= 1'b0;
      r_sample     <= 10'd0;
      r_idx        <= 4'd0;
      r_d0_sent    <= 1'b0;
      r_lsb_phase  <= 1'b0;
      r_sdo        <= 1'b0;
      r_conv_done  <= 1'b0;
      r_last_cmd   <= 2'b00;
      r_conv_count <= 8'd0;
    end else begin
      r_conv_done <= 1'b0;
      if (w_cs_high) begin
        r_bit_cnt   <= 2'd0;
        r_idx       <= 4'd0;
        r_d0_sent   <= 1'b0;
        r_lsb_phase <= 1'b0;
        r_sdo       <= 1'b0;
      end else begin
        case (r_state)
          c_WAIT_START: if (w_sck_rise && w_sdi) r_bit_cnt <= 2'd0;
          c_CMD: begin
            if (w_sck_rise) begin
              r_bit_cnt <= r_bit_cnt + 2'd1;
              case (r_bit_cnt)
                2'd0:    r_sgl <= w_sdi;
                2'd1:    r_odd <= w_sdi;
                default: begin
                  r_msbf     <= w_sdi;
                  r_sample   <= w_sample;
                  r_last_cmd <= {r_sgl, r_odd};
                end
              endcase
            end
          end
          c_NULLBIT: begin
            if (w_sck_fall) begin
              r_sdo <= 1'b0;
              r_idx <= c_MSB_IDX;
            end
          end
          c_DATA: begin
            if (r_lsb_phase) begin
              if (w_sck_fall) begin
                r_sdo <= r_sample[r_idx];
                r_idx <= r_idx + 4'd1;
              end
            end else if (!r_d0_sent) begin
              if (w_sck_fall) begin
                r_sdo <= r_sample[r_idx];
                if (r_idx == 4'd0) r_d0_sent <= 1'b1;
                else               r_idx     <= r_idx - 4'd1;
              end
            end else if (w_sck_rise) begin
              // Initiator has just sampled D0: the conversion counts as done.
              r_conv_done  <= 1'b1;
              r_conv_count <= r_conv_count + 8'd1;
              if (!r_msbf) begin
                r_lsb_phase <= 1'b1;
                r_idx       <= 4'd1;
              end
            end
          end
          c_TRAIL: if (w_sck_fall) r_sdo <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
